// File: rtl/fpu_addsub_seq_if.sv
// Bus-side handshake for the single-precision add/sub sequencer.
// slave: the sequencer. master: the operand/result register side.
interface fpu_addsub_seq_if #(
  parameter int OP_W = 4
);
  logic            start;
  logic [OP_W-1:0] operation;
  logic [31:0]     operand_a;
  logic [31:0]     operand_b;
  logic            end_ack;
  logic [31:0]     result;
  logic [7:0]      status;
  logic            busy;
  logic            cmd_end;

  modport slave (
    input  start, operation, operand_a, operand_b, end_ack,
    output result, status, busy, cmd_end
  );

  modport master (
    output start, operation, operand_a, operand_b, end_ack,
    input  result, status, busy, cmd_end
  );
endinterface

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/sub sequencer.
// Flow: unpack, 1-bit/cycle alignment, 25-bit add/sub, 1-bit/cycle normalise, pack.
// Subnormal inputs are treated as zero; mul/div opcodes finish at once with err set.
// Optional build macro FPU_ROUND_NEAREST_EN: keep guard/round/sticky through alignment
// and round to nearest-even in PACK. Without it, results are truncated.
//
// state  | meaning
// IDLE   | waiting for start
// UNPACK | split captured operands into sign/exponent/mantissa
// ALIGN  | shift smaller-exponent mantissa right one bit per cycle
// ADDSUB | magnitude add or larger-minus-smaller subtract
// NORM   | carry right shift, or left shift one bit per cycle until bit 23 set
// PACK   | range check, optional rounding, build result and status
// DONE   | cmd_end held until end_ack or a new start
module fpu_addsub_seq #(
  parameter int MAX_ALIGN = 26,
  parameter int OP_W      = 4
) (
  input  logic            clk,
  input  logic            arst,
  fpu_addsub_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADDSUB,
    S_NORM,
    S_PACK,
    S_DONE
  } state_t;

  localparam logic [7:0] MAX_ALIGN_C = 8'(MAX_ALIGN);

  state_t            state_q;
  logic [31:0]       op_a_q;
  logic [31:0]       op_b_q;
  logic              op_sub_q;
  // working mantissas: [26:3] = 1.frac, [2:0] = guard/round/sticky
  logic [26:0]       ma_q;
  logic [26:0]       mb_q;
  logic signed [9:0] exp_q;
  logic [7:0]        tgt_q;
  logic [7:0]        cnt_q;
  logic              flush_q;
  logic              shift_a_q;
  logic              sign_a_q;
  logic              sign_b_q;
  // [27] = carry out of the add
  logic [27:0]       mant_q;
  logic              sign_r_q;
  logic              zero_q;
  logic [31:0]       result_q;
  logic [7:0]        status_q;
  logic              busy_q;
  logic              cmd_end_q;

  logic [7:0]        ea_d;
  logic [7:0]        eb_d;
  logic [7:0]        diff_d;
  logic [26:0]       ma_d;
  logic [26:0]       mb_d;
  logic              a_ge_b_d;

  logic [26:0]       sm_src_d;
  logic [26:0]       sm_shift_d;
  logic [7:0]        cnt_inc_d;

  logic [27:0]       norm_rs_d;

  logic              round_up_d;
  logic [24:0]       mant_rnd_d;
  logic signed [9:0] exp_rnd_d;
  logic [31:0]       pack_result_d;
  logic [7:0]        pack_status_d;

  assign bus.result  = result_q;
  assign bus.status  = status_q;
  assign bus.busy    = busy_q;
  assign bus.cmd_end = cmd_end_q;

  // Unpack: zero exponent means zero operand, larger exponent becomes the working exponent
  always_comb begin
    ea_d     = op_a_q[30:23];
    eb_d     = op_b_q[30:23];
    ma_d     = (ea_d == 8'd0) ? 27'd0 : {1'b1, op_a_q[22:0], 3'b000};
    mb_d     = (eb_d == 8'd0) ? 27'd0 : {1'b1, op_b_q[22:0], 3'b000};
    a_ge_b_d = (ea_d >= eb_d);
    diff_d   = a_ge_b_d ? (ea_d - eb_d) : (eb_d - ea_d);
  end

  // One alignment step of the smaller operand; the last step flushes it when the gap is too large
  always_comb begin
    sm_src_d   = shift_a_q ? ma_q : mb_q;
    cnt_inc_d  = cnt_q + 8'd1;
    sm_shift_d = {1'b0, sm_src_d[26:2], sm_src_d[1] | sm_src_d[0]};
`ifdef FPU_ROUND_NEAREST_EN
    if (flush_q && (cnt_inc_d == tgt_q)) begin
      sm_shift_d = {26'd0, |sm_src_d};
    end
`else
    sm_shift_d[2:0] = 3'b000;
    if (flush_q && (cnt_inc_d == tgt_q)) begin
      sm_shift_d = 27'd0;
    end
`endif
  end

  // Carry normalisation: one right shift, folding the dropped bit into sticky when rounding
  always_comb begin
    norm_rs_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
`ifdef FPU_ROUND_NEAREST_EN
`else
    norm_rs_d[2:0] = 3'b000;
`endif
  end

  // Pack: optional round-to-nearest-even, re-normalise a rounding carry, exponent range check
  always_comb begin
`ifdef FPU_ROUND_NEAREST_EN
    round_up_d = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
`else
    round_up_d = 1'b0;
`endif
    mant_rnd_d = {1'b0, mant_q[26:3]} + {24'd0, round_up_d};
    exp_rnd_d  = exp_q;
    if (mant_rnd_d[24]) begin
      mant_rnd_d = {1'b0, mant_rnd_d[24:1]};
      exp_rnd_d  = exp_q + 10'sd1;
    end
    if (zero_q) begin
      pack_result_d = 32'd0;
      pack_status_d = 8'h08;
    end else if (exp_rnd_d >= 10'sd255) begin
      pack_result_d = {sign_r_q, 8'hFF, 23'd0};
      pack_status_d = {3'b000, sign_r_q, 4'b0010};
    end else if (exp_rnd_d <= 10'sd0) begin
      pack_result_d = 32'd0;
      pack_status_d = 8'h0C;
    end else begin
      pack_result_d = {sign_r_q, exp_rnd_d[7:0], mant_rnd_d[22:0]};
      pack_status_d = {3'b000, sign_r_q, 4'b0000};
    end
  end

  // Sequencer FSM with registered result/status/busy/cmd_end
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= S_IDLE;
      result_q  <= 32'd0;
      status_q  <= 8'd0;
      busy_q    <= 1'b0;
      cmd_end_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (bus.operation[OP_W-1:1] == '0) begin
              op_a_q    <= bus.operand_a;
              op_b_q    <= bus.operand_b;
              op_sub_q  <= bus.operation[0];
              busy_q    <= 1'b1;
              cmd_end_q <= 1'b0;
              state_q   <= S_UNPACK;
            end else begin
              result_q  <= 32'd0;
              status_q  <= 8'h01;
              cmd_end_q <= 1'b1;
              state_q   <= S_DONE;
            end
          end else if ((state_q == S_DONE) && bus.end_ack) begin
            cmd_end_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end

        S_UNPACK: begin
          ma_q      <= ma_d;
          mb_q      <= mb_d;
          sign_a_q  <= op_a_q[31];
          sign_b_q  <= op_b_q[31] ^ op_sub_q;
          exp_q     <= {2'b00, (a_ge_b_d ? ea_d : eb_d)};
          shift_a_q <= ~a_ge_b_d;
          cnt_q     <= 8'd0;
          flush_q   <= (diff_d > MAX_ALIGN_C);
          tgt_q     <= (diff_d > MAX_ALIGN_C) ? MAX_ALIGN_C : diff_d;
          state_q   <= (diff_d == 8'd0) ? S_ADDSUB : S_ALIGN;
        end

        S_ALIGN: begin
          if (shift_a_q) begin
            ma_q <= sm_shift_d;
          end else begin
            mb_q <= sm_shift_d;
          end
          cnt_q <= cnt_inc_d;
          if (cnt_inc_d == tgt_q) begin
            state_q <= S_ADDSUB;
          end
        end

        S_ADDSUB: begin
          zero_q <= 1'b0;
          if (sign_a_q == sign_b_q) begin
            mant_q   <= {1'b0, ma_q} + {1'b0, mb_q};
            sign_r_q <= sign_a_q;
          end else if (ma_q > mb_q) begin
            mant_q   <= {1'b0, ma_q - mb_q};
            sign_r_q <= sign_a_q;
          end else if (mb_q > ma_q) begin
            mant_q   <= {1'b0, mb_q - ma_q};
            sign_r_q <= sign_b_q;
          end else begin
            mant_q   <= 28'd0;
            sign_r_q <= 1'b0;
          end
          state_q <= S_NORM;
        end

        S_NORM: begin
          if (mant_q == 28'd0) begin
            zero_q  <= 1'b1;
            state_q <= S_PACK;
          end else if (mant_q[27]) begin
            mant_q <= norm_rs_d;
            exp_q  <= exp_q + 10'sd1;
          end else if (!mant_q[26]) begin
            mant_q <= {mant_q[26:0], 1'b0};
            exp_q  <= exp_q - 10'sd1;
          end else begin
            state_q <= S_PACK;
          end
        end

        S_PACK: begin
          result_q  <= pack_result_d;
          status_q  <= pack_status_d;
          busy_q    <= 1'b0;
          cmd_end_q <= 1'b1;
          state_q   <= S_DONE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed bench for fpu_addsub_seq (default truncating build).
// Expected result/status/latency are pushed to a scoreboard before each command
// and popped when cmd_end rises. Latency = clock edges after the start edge.
module tb_fpu_addsub_seq;
  logic clk = 1'b0;
  logic arst;

  always #5 clk = ~clk;

  fpu_addsub_seq_if bus ();

  fpu_addsub_seq dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [7:0]  st;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic ack);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operation = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.end_ack   = ack;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.end_ack   = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.operation = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_end(input bit poke_busy, output int lat, output bit seen);
    lat  = 0;
    seen = bus.cmd_end;
    while (!seen && lat < 200) begin
      if (poke_busy && lat == 1) begin
        bus.start     = 1'b1;
        bus.operation = 4'd3;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
      seen = bus.cmd_end;
    end
  endtask

  task automatic finish_cmd(input string tag, input bit poke_busy);
    int   lat;
    bit   seen;
    exp_t e;
    wait_end(poke_busy, lat, seen);
    check({tag, " cmd_end"}, 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " result"},  bus.result,       e.res);
      check({tag, " status"},  32'(bus.status),  32'(e.st));
      check({tag, " latency"}, 32'(lat),         32'(e.lat));
      check({tag, " busy"},    32'(bus.busy),    32'd0);
    end
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    bus.end_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.end_ack = 1'b0;
    check({tag, " ack"}, 32'(bus.cmd_end), 32'd0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                     input logic [31:0] res, input logic [7:0] st, input int lat,
                     input string tag);
    sb.push_back('{res, st, lat});
    launch(a, b, op, 1'b0);
    finish_cmd(tag, 1'b0);
    ack(tag);
  endtask

  initial begin
    arst          = 1'b1;
    bus.start     = 1'b0;
    bus.operation = 4'd0;
    bus.operand_a = 32'd0;
    bus.operand_b = 32'd0;
    bus.end_ack   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    check("reset result",  bus.result,          32'd0);
    check("reset status",  32'(bus.status),     32'd0);
    check("reset busy",    32'(bus.busy),       32'd0);
    check("reset cmd_end", 32'(bus.cmd_end),    32'd0);

    run(32'h3F800000, 32'h3F800000, 4'd0, 32'h40000000, 8'h00, 5,  "add_1p1");
    run(32'h3FF80000, 32'h3F380000, 4'd1, 32'h3F9C0000, 8'h00, 5,  "sub_align1");
    run(32'h40490FDB, 32'h40490FDB, 4'd1, 32'h00000000, 8'h08, 4,  "cancel");
    run(32'h3F800000, 32'hCB800000, 4'd0, 32'hCB800000, 8'h10, 28, "sign_flush");
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 4'd0, 32'h7F800000, 8'h02, 5,  "overflow");
    run(32'h3F800000, 32'h3F400000, 4'd1, 32'h3E800000, 8'h00, 7,  "norm_left2");
    run(32'h00800000, 32'h00C00000, 4'd1, 32'h00000000, 8'h0C, 5,  "underflow");
    run(32'h40000000, 32'h40400000, 4'd1, 32'hBF800000, 8'h10, 5,  "neg_result");
    run(32'h00000000, 32'h3F800000, 4'd0, 32'h3F800000, 8'h00, 30, "zero_maxalign");
    run(32'h3F800000, 32'hBF800000, 4'd1, 32'h40000000, 8'h00, 5,  "sub_negb");

    // unsupported opcode finishes on the start edge
    sb.push_back('{32'h00000000, 8'h01, 0});
    launch(32'h3F800000, 32'h3F800000, 4'd2, 1'b0);
    finish_cmd("bad_op", 1'b0);
    ack("bad_op");

    // a second start while busy must not disturb the running command
    sb.push_back('{32'h40000000, 8'h00, 5});
    launch(32'h3F800000, 32'h3F800000, 4'd0, 1'b0);
    finish_cmd("busy_start", 1'b1);

    // start and end_ack together in DONE: start wins
    sb.push_back('{32'hBF800000, 8'h10, 5});
    launch(32'h40000000, 32'h40400000, 4'd1, 1'b1);
    check("start_wins cmd_end", 32'(bus.cmd_end), 32'd0);
    check("start_wins busy",    32'(bus.busy),    32'd1);
    finish_cmd("start_wins", 1'b0);

    // reset in the middle of a long alignment aborts with no cmd_end
    launch(32'h00000000, 32'h3F800000, 4'd0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy",    32'(bus.busy),    32'd0);
    check("abort cmd_end", 32'(bus.cmd_end), 32'd0);
    check("abort result",  bus.result,       32'd0);
    check("abort status",  32'(bus.status),  32'd0);
    @(negedge clk);
    arst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort quiet cmd_end", 32'(bus.cmd_end), 32'd0);
    check("abort quiet busy",    32'(bus.busy),    32'd0);

    run(32'h3F800000, 32'h3F800000, 4'd0, 32'h40000000, 8'h00, 5, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
